inet_csum_acc: RTL and testbench

Parametrised successor to the byte-serial 16-bit ones'-complement checksum unit. It accepts framed packet data DATA_BYTES bytes per beat with per-lane byte enables, and keeps network byte order across odd/even beat boundaries. Carries are folded end-around. Per packet it emits the folded sum, the final checksum and the byte length. It sits in the FPGA packet-TX path, ahead of the IP/UDP header inserter.

---
 rtl/inet_csum_acc_pkg.sv | 33 +++
 rtl/inet_csum_acc_if.sv | 31 +++
 rtl/inet_csum_acc_lane_place.sv | 38 +++
 rtl/inet_csum_acc.sv | 113 +++++++++++
 tb/tb_inet_csum_acc.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inet_csum_acc_pkg.sv
// Shared definitions for the Internet checksum accumulator.
//   CSUM_W      : checksum word width (16)
//   FOLD_IN_W   : width of the value handed to fold()
//   fold()      : end-around carry fold of a wide sum into 16 bits
//   popcount8() : number of set bits in a (zero-padded) keep vector
//   keep_parity8(): parity of a (zero-padded) keep vector
package inet_csum_acc_pkg;

  localparam int CSUM_W    = 16;
  localparam int FOLD_IN_W = 32;

  // Two passes are enough: the first leaves at most a 17-bit value, the
  // second cannot carry out again. A nonzero input never folds to 0x0000.
  function automatic logic [CSUM_W-1:0] fold(input logic [FOLD_IN_W-1:0] x);
    logic [CSUM_W:0] t;
    logic [CSUM_W:0] u;
    t = {1'b0, x[15:0]} + {1'b0, x[31:16]};
    u = {1'b0, t[15:0]} + {16'h0000, t[16]};
    return u[CSUM_W-1:0];
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  function automatic logic keep_parity8(input logic [7:0] k);
    return ^k;
  endfunction

endpackage

// File: rtl/inet_csum_acc_if.sv
// Beat/result bundle for inet_csum_acc.
//   init/init_sum           : seed load
//   in_valid/in_data/in_keep/in_last : framed beat, lane 0 = earliest byte
//   out_valid/out_sum/out_csum/out_len : per-packet result
// master drives beats (packet source), slave is the accumulator.
interface inet_csum_acc_if #(
  parameter int DATA_BYTES = 2
);
  import inet_csum_acc_pkg::*;

  logic                    init;
  logic [CSUM_W-1:0]       init_sum;
  logic                    in_valid;
  logic [8*DATA_BYTES-1:0] in_data;
  logic [DATA_BYTES-1:0]   in_keep;
  logic                    in_last;
  logic                    out_valid;
  logic [CSUM_W-1:0]       out_sum;
  logic [CSUM_W-1:0]       out_csum;
  logic [15:0]             out_len;

  modport master (
    output init, init_sum, in_valid, in_data, in_keep, in_last,
    input  out_valid, out_sum, out_csum, out_len
  );

  modport slave (
    input  init, init_sum, in_valid, in_data, in_keep, in_last,
    output out_valid, out_sum, out_csum, out_len
  );
endinterface

// File: rtl/inet_csum_acc_lane_place.sv
// csum_lane_place: combinational byte placement and beat partial sum.
//   phase   : packet phase before this beat (1 = next byte is a low byte)
//   data    : beat bytes, lane 0 = earliest
//   keep    : per-lane byte enable
//   partial : sum of the placed 16-bit contributions of kept lanes
module csum_lane_place
  import inet_csum_acc_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int PW         = CSUM_W + $clog2(DATA_BYTES) + 1
) (
  input  logic                    phase,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [PW-1:0]           partial
);

  logic              ph;
  logic [CSUM_W-1:0] word;
  logic [PW-1:0]     sum;

  // ph walks across the lanes and flips only on kept lanes, so each lane
  // sees packet phase XOR parity of the kept lanes below it.
  always_comb begin
    ph   = phase;
    word = '0;
    sum  = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (keep[i]) begin
        word = ph ? {8'h00, data[8*i +: 8]} : {data[8*i +: 8], 8'h00};
        sum  = sum + PW'(word);
        ph   = ~ph;
      end
    end
    partial = sum;
  end

endmodule

// File: rtl/inet_csum_acc.sv
// inet_csum_acc: multi-byte-per-beat 16-bit ones'-complement checksum.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : inet_csum_acc_if slave (seed load, framed beats, results)
// Two register stages: stage 1 holds the beat partial sum and length
// increment, stage 2 folds into the accumulator and updates the outputs.
// Last beat in cycle N -> out_valid in cycle N+2.
module inet_csum_acc
  import inet_csum_acc_pkg::*;
#(
  parameter int DATA_BYTES   = 2,
  parameter bit OUT_INVERT   = 1'b1,
  parameter bit UDP_ZERO_SUB = 1'b0
) (
  input logic           clk,
  input logic           rst,
  inet_csum_acc_if.slave bus
);

  localparam int PW = CSUM_W + $clog2(DATA_BYTES) + 1;

  logic [CSUM_W-1:0] seed;
  logic              in_pkt;
  logic              phase;
  logic [7:0]        keep8;
  logic [PW-1:0]     partial;

  logic              s1_vld;
  logic              s1_first;
  logic              s1_last;
  logic [PW-1:0]     s1_partial;
  logic [3:0]        s1_inc;
  logic [CSUM_W-1:0] s1_seed;

  logic [CSUM_W-1:0] acc;
  logic [15:0]       len_acc;

  logic [CSUM_W-1:0] base;
  logic [CSUM_W-1:0] sum_c;
  logic [CSUM_W-1:0] csum_c;
  logic [16:0]       len_t;
  logic [15:0]       len_c;

  assign keep8 = 8'(bus.in_keep);

  csum_lane_place #(.DATA_BYTES(DATA_BYTES), .PW(PW)) u_place (
    .phase   (phase),
    .data    (bus.in_data),
    .keep    (bus.in_keep),
    .partial (partial)
  );

  // Stage 1. The packet's seed is captured with its first beat so a later
  // init cannot reach a packet already in the pipe; init on the first beat
  // itself bypasses the seed register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed       <= '0;
      in_pkt     <= 1'b0;
      phase      <= 1'b0;
      s1_vld     <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_partial <= '0;
      s1_inc     <= '0;
      s1_seed    <= '0;
    end else begin
      if (bus.init) seed <= bus.init_sum;
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        in_pkt     <= ~bus.in_last;
        phase      <= bus.in_last ? 1'b0 : (phase ^ keep_parity8(keep8));
        s1_first   <= ~in_pkt;
        s1_last    <= bus.in_last;
        s1_partial <= partial;
        s1_inc     <= popcount8(keep8);
        s1_seed    <= bus.init ? bus.init_sum : seed;
      end
    end
  end

  // Stage 2 next values.
  always_comb begin
    base   = s1_first ? s1_seed : acc;
    sum_c  = fold(FOLD_IN_W'(base) + FOLD_IN_W'(s1_partial));
    len_t  = {1'b0, (s1_first ? 16'h0000 : len_acc)} + 17'(s1_inc);
    len_c  = len_t[16] ? 16'hFFFF : len_t[15:0];
    csum_c = OUT_INVERT ? ~sum_c : sum_c;
    if (UDP_ZERO_SUB && csum_c == '0) csum_c = 16'hFFFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      len_acc      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_csum  <= '0;
      bus.out_len   <= '0;
    end else begin
      bus.out_valid <= s1_vld & s1_last;
      if (s1_vld) begin
        acc     <= sum_c;
        len_acc <= len_c;
      end
      if (s1_vld && s1_last) begin
        bus.out_sum  <= sum_c;
        bus.out_csum <= csum_c;
        bus.out_len  <= len_c;
      end
    end
  end

endmodule

// File: tb/tb_inet_csum_acc.sv
module tb_inet_csum_acc;

  typedef struct {
    logic [47:0] v;   // {sum, csum, len}
    int          cyc;
  } res_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tdrv;
  int   n_chk;
  int   n_fail;
  logic [15:0] m_seed4;
  logic [15:0] m_seed1;
  res_t got4[$];
  res_t got1[$];

  localparam logic [31:0] VD [4] = '{32'h1C000045, 32'h0302AA01, 32'h0100FFFF, 32'h0000FFFF};
  localparam logic [3:0]  VK [4] = '{4'b1111, 4'b1101, 4'b1111, 4'b0011};
  localparam logic [47:0] VE [4] = '{{16'h451C, 16'hBAE3, 16'd4}, {16'h0402, 16'hFBFD, 16'd3},
                                     {16'h0001, 16'hFFFE, 16'd4}, {16'hFFFF, 16'h0000, 16'd2}};

  inet_csum_acc_if #(.DATA_BYTES(4)) b4 ();
  inet_csum_acc_if #(.DATA_BYTES(1)) b1 ();

  inet_csum_acc #(.DATA_BYTES(4), .OUT_INVERT(1'b1), .UDP_ZERO_SUB(1'b0)) dut4 (
    .clk (clk), .rst (rst), .bus (b4.slave));
  inet_csum_acc #(.DATA_BYTES(1), .OUT_INVERT(1'b1), .UDP_ZERO_SUB(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b4.out_valid) got4.push_back('{{b4.out_sum, b4.out_csum, b4.out_len}, cyc});
    if (b1.out_valid) got1.push_back('{{b1.out_sum, b1.out_csum, b1.out_len}, cyc});
  end

  // Reference: plain integer sum of big-endian byte pairs on top of the
  // seed, end-around folded once at the end.
  function automatic logic [47:0] model(input logic [7:0] q[$], input logic [15:0] seed, input bit uzs);
    longint t;
    logic [15:0] s, c, n;
    t = longint'(seed);
    for (int i = 0; i < q.size(); i++)
      t += (i % 2 == 0) ? (longint'(q[i]) * 256) : longint'(q[i]);
    while ((t >> 16) != 0) t = (t & 'hFFFF) + (t >> 16);
    s = t[15:0];
    c = ~s;
    if (uzs && c == 16'h0000) c = 16'hFFFF;
    n = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
    return {s, c, n};
  endfunction

  task automatic beat4(input logic [31:0] d, input logic [3:0] k, input logic l,
                       input logic ini, input logic [15:0] is);
    @(negedge clk);
    b4.in_valid = 1'b1; b4.in_data = d; b4.in_keep = k; b4.in_last = l;
    b4.init = ini; b4.init_sum = is;
    tdrv = cyc;
    if (ini) m_seed4 = is;
  endtask

  task automatic idle4(input int n, input logic ini, input logic [15:0] is);
    repeat (n) begin
      @(negedge clk);
      b4.in_valid = 1'b0; b4.in_last = 1'b0; b4.init = ini; b4.init_sum = is;
      if (ini) m_seed4 = is;
    end
  endtask

  task automatic beat1(input logic [7:0] d, input logic k, input logic l,
                       input logic ini, input logic [15:0] is);
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_data = d; b1.in_keep = k; b1.in_last = l;
    b1.init = ini; b1.init_sum = is;
    tdrv = cyc;
    if (ini) m_seed1 = is;
  endtask

  task automatic idle1(input int n);
    repeat (n) begin
      @(negedge clk);
      b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.init = 1'b0;
    end
  endtask

  task automatic wait4(input int n, output bit ok);
    for (int i = 0; i < 100 && got4.size() < n; i++) @(posedge clk);
    ok = (got4.size() >= n);
  endtask

  task automatic wait1(input int n, output bit ok);
    for (int i = 0; i < 100 && got1.size() < n; i++) @(posedge clk);
    ok = (got1.size() >= n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({b4.out_valid, b4.out_sum, b4.out_csum, b4.out_len} !== 49'h0) begin
      n_fail++;
      $display("FAIL reset4: got v=%b %h/%h/%0d, want all zero", b4.out_valid, b4.out_sum, b4.out_csum, b4.out_len);
    end
    n_chk++;
    if ({b1.out_valid, b1.out_sum, b1.out_csum, b1.out_len} !== 49'h0) begin
      n_fail++;
      $display("FAIL reset1: got v=%b %h/%h/%0d, want all zero", b1.out_valid, b1.out_sum, b1.out_csum, b1.out_len);
    end
    rst = 1'b0;
    m_seed4 = 16'h0; m_seed1 = 16'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_vectors4;
    bit ok;
    int t;
    got4.delete();
    for (int i = 0; i < 4; i++) begin
      beat4(VD[i], VK[i], 1'b1, 1'b0, 16'h0);
      t = tdrv;
      idle4(1, 1'b0, 16'h0);
      wait4(i + 1, ok);
      n_chk++;
      if (!ok || got4[i].v !== VE[i] || got4[i].cyc != t + 2) begin
        n_fail++;
        $display("FAIL vector4[%0d]: got %h at cyc %0d (seen=%0b), want %h at cyc %0d",
                 i, ok ? got4[i].v : 48'h0, ok ? got4[i].cyc : -1, ok, VE[i], t + 2);
      end
    end
  endtask

  task automatic test_vectors1;
    logic [7:0]  pk[$];
    logic [47:0] ex[3];
    bit ok;
    int t;
    got1.delete();
    ex = '{{16'h0402, 16'hFBFD, 16'd3}, {16'hFFFF, 16'hFFFF, 16'd2}, {16'hAB00, 16'h54FF, 16'd1}};
    for (int p = 0; p < 3; p++) begin
      pk.delete();
      if (p == 0) pk = '{8'h01, 8'h02, 8'h03};
      else if (p == 1) pk = '{8'hFF, 8'hFF};
      else pk = '{8'hAB};
      for (int i = 0; i < pk.size(); i++) beat1(pk[i], 1'b1, i == pk.size() - 1, 1'b0, 16'h0);
      t = tdrv;
      idle1(1);
      wait1(p + 1, ok);
      n_chk++;
      if (!ok || got1[p].v !== ex[p] || got1[p].cyc != t + 2) begin
        n_fail++;
        $display("FAIL vector1[%0d]: got %h at cyc %0d (seen=%0b), want %h at cyc %0d",
                 p, ok ? got1[p].v : 48'h0, ok ? got1[p].cyc : -1, ok, ex[p], t + 2);
      end
    end
  endtask

  task automatic test_init_seed;
    logic [47:0] ex[4];
    bit ok;
    got4.delete();
    ex = '{{16'h1235, 16'hEDCA, 16'd2}, {16'h1534, 16'hEACB, 16'd1},
           {16'h2254, 16'hDDAB, 16'd2}, {16'h5555, 16'hAAAA, 16'd0}};
    beat4(32'h00000100, 4'b0011, 1'b1, 1'b1, 16'h1234);   // init bypass on first beat
    idle4(2, 1'b0, 16'h0);
    beat4(32'h00000003, 4'b0001, 1'b1, 1'b0, 16'h0);      // reuses seed 0x1234
    idle4(1, 1'b0, 16'h0);
    beat4(32'h00000010, 4'b0001, 1'b0, 1'b0, 16'h0);      // odd first beat
    idle4(2, 1'b0, 16'h0);                                // idle inside packet
    beat4(32'h00000020, 4'b0001, 1'b0, 1'b1, 16'h5555);   // init mid-packet
    beat4(32'hDEADBEEF, 4'b0000, 1'b1, 1'b0, 16'h0);      // empty last beat
    beat4(32'hDEADBEEF, 4'b0000, 1'b1, 1'b0, 16'h0);      // empty packet
    idle4(1, 1'b0, 16'h0);
    wait4(4, ok);
    idle4(3, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= got4.size() || got4[i].v !== ex[i]) begin
        n_fail++;
        $display("FAIL init_seed[%0d]: got %h, want %h (results seen %0d)",
                 i, (i < got4.size()) ? got4[i].v : 48'h0, ex[i], got4.size());
      end
    end
    n_chk++;
    if (got4.size() != 4) begin
      n_fail++;
      $display("FAIL init_seed_count: got %0d results, want 4", got4.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int t;
    got4.delete();
    beat4(32'h00000201, 4'b0011, 1'b1, 1'b1, 16'h0000);
    t = tdrv;
    beat4(32'h00000003, 4'b0001, 1'b1, 1'b1, 16'h1234);
    idle4(1, 1'b0, 16'h0);
    wait4(2, ok);
    n_chk++;
    if (!ok || got4[0].v !== {16'h0102, 16'hFEFD, 16'd2} || got4[0].cyc != t + 2) begin
      n_fail++;
      $display("FAIL b2b_a: got %h at cyc %0d, want 0102fefd0002 at cyc %0d",
               ok ? got4[0].v : 48'h0, ok ? got4[0].cyc : -1, t + 2);
    end
    n_chk++;
    if (!ok || got4[1].v !== {16'h1534, 16'hEACB, 16'd1} || got4[1].cyc != t + 3) begin
      n_fail++;
      $display("FAIL b2b_b: got %h at cyc %0d, want 1534eacb0001 at cyc %0d",
               ok ? got4[1].v : 48'h0, ok ? got4[1].cyc : -1, t + 3);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    got4.delete();
    beat4(32'h000000AA, 4'b0001, 1'b0, 1'b0, 16'h0);
    beat4(32'h000000BB, 4'b0001, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    b4.in_valid = 1'b0; rst = 1'b1; m_seed4 = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    idle4(4, 1'b0, 16'h0);
    n_chk++;
    if (got4.size() != 0 || {b4.out_valid, b4.out_sum, b4.out_csum, b4.out_len} !== 49'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d results, outputs %h/%h/%0d, want none and zero",
               got4.size(), b4.out_sum, b4.out_csum, b4.out_len);
    end
    beat4(32'h00000007, 4'b0001, 1'b1, 1'b0, 16'h0);
    idle4(1, 1'b0, 16'h0);
    wait4(1, ok);
    n_chk++;
    if (!ok || got4[0].v !== {16'h0700, 16'hF8FF, 16'd1}) begin
      n_fail++;
      $display("FAIL reset_restart: got %h, want 0700f8ff0001", ok ? got4[0].v : 48'h0);
    end
  endtask

  task automatic test_random4;
    logic [7:0]  bytes[$];
    logic [47:0] ex[$];
    int          exc[$];
    logic [31:0] d;
    logic [3:0]  k;
    logic        ini;
    logic [15:0] is, pseed;
    int          nb;
    bit          ok;
    got4.delete();
    for (int p = 0; p < 60; p++) begin
      nb = $urandom_range(1, 6);
      bytes.delete();
      for (int b = 0; b < nb; b++) begin
        d   = $urandom;
        k   = 4'($urandom);
        ini = ($urandom_range(0, 3) == 0);
        is  = 16'($urandom);
        if (b == 0) pseed = ini ? is : m_seed4;
        for (int l = 0; l < 4; l++) if (k[l]) bytes.push_back(d[8*l +: 8]);
        beat4(d, k, b == nb - 1, ini, is);
        if (b == nb - 1) begin
          ex.push_back(model(bytes, pseed, 1'b0));
          exc.push_back(tdrv + 2);
        end
        if ($urandom_range(0, 3) == 0) idle4($urandom_range(1, 2), $urandom_range(0, 1) == 1, 16'($urandom));
      end
    end
    idle4(1, 1'b0, 16'h0);
    wait4(ex.size(), ok);
    idle4(3, 1'b0, 16'h0);
    for (int i = 0; i < ex.size(); i++) begin
      n_chk++;
      if (i >= got4.size() || got4[i].v !== ex[i] || got4[i].cyc != exc[i]) begin
        n_fail++;
        $display("FAIL random4[%0d]: got %h at cyc %0d, want %h at cyc %0d", i,
                 (i < got4.size()) ? got4[i].v : 48'h0, (i < got4.size()) ? got4[i].cyc : -1, ex[i], exc[i]);
      end
    end
    n_chk++;
    if (got4.size() != ex.size()) begin
      n_fail++;
      $display("FAIL random4_count: got %0d results, want %0d", got4.size(), ex.size());
    end
  endtask

  task automatic test_random1;
    logic [7:0]  bytes[$];
    logic [47:0] ex[$];
    logic [7:0]  d;
    logic        k, ini;
    logic [15:0] is, pseed;
    int          nb;
    bit          ok;
    got1.delete();
    for (int p = 0; p < 25; p++) begin
      nb = $urandom_range(1, 9);
      bytes.delete();
      for (int b = 0; b < nb; b++) begin
        d   = 8'($urandom);
        k   = ($urandom_range(0, 4) != 0);
        ini = (b == 0) && ($urandom_range(0, 2) == 0);
        is  = 16'($urandom);
        if (b == 0) pseed = ini ? is : m_seed1;
        if (k) bytes.push_back(d);
        beat1(d, k, b == nb - 1, ini, is);
      end
      ex.push_back(model(bytes, pseed, 1'b1));
    end
    idle1(1);
    wait1(ex.size(), ok);
    idle1(3);
    for (int i = 0; i < ex.size(); i++) begin
      n_chk++;
      if (i >= got1.size() || got1[i].v !== ex[i]) begin
        n_fail++;
        $display("FAIL random1[%0d]: got %h, want %h", i, (i < got1.size()) ? got1[i].v : 48'h0, ex[i]);
      end
    end
    n_chk++;
    if (got1.size() != ex.size()) begin
      n_fail++;
      $display("FAIL random1_count: got %0d results, want %0d", got1.size(), ex.size());
    end
  endtask

  task automatic test_len_sat;
    logic [7:0]  bytes[$];
    logic [47:0] ex;
    logic [31:0] d;
    logic [15:0] pseed;
    bit          ok;
    got4.delete();
    pseed = m_seed4;
    for (int b = 0; b < 16400; b++) begin
      d = $urandom;
      for (int l = 0; l < 4; l++) bytes.push_back(d[8*l +: 8]);
      beat4(d, 4'b1111, b == 16399, 1'b0, 16'h0);
    end
    ex = model(bytes, pseed, 1'b0);
    idle4(1, 1'b0, 16'h0);
    wait4(1, ok);
    n_chk++;
    if (!ok || got4[0].v !== ex) begin
      n_fail++;
      $display("FAIL len_sat: got %h, want %h", ok ? got4[0].v : 48'h0, ex);
    end
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; tdrv = 0;
    m_seed4 = 16'h0; m_seed1 = 16'h0;
    rst = 1'b1;
    b4.init = 1'b0; b4.init_sum = '0; b4.in_valid = 1'b0; b4.in_data = '0; b4.in_keep = '0; b4.in_last = 1'b0;
    b1.init = 1'b0; b1.init_sum = '0; b1.in_valid = 1'b0; b1.in_data = '0; b1.in_keep = '0; b1.in_last = 1'b0;
    test_reset;
    test_vectors4;
    test_vectors1;
    test_init_seed;
    test_back_to_back;
    test_reset_mid;
    test_random4;
    test_random1;
    test_len_sat;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
